uart_tx_arbiter: RTL

- Shares the single UART transmit path (tx_wen / uart_din / tx_full on mmio_bus) between NREQ byte-stream requesters, e.g. CPU MMIO store path and the debug/trace monitor.
- Arbitrates at message granularity. A granted requester holds the UART until it sends a byte flagged last, so messages never interleave on the serial line.
- Sits between the requesters and uart_controller. Drives the controller's tx_wen/uart_din and observes its tx_full.

---
 rtl/uart_tx_arbiter.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: message-granular round-robin share of one UART tx path.
// Optional idle-owner forced release: define UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter #(
  parameter int NREQ    = 2,
  parameter int TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              Rst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [8*NREQ-1:0] req_data,
  input  logic [NREQ-1:0]   req_last,
  output logic [NREQ-1:0]   req_ready,
  input  logic              tx_full,
  output logic              tx_wen,
  output logic [7:0]        uart_din,
  output logic [NREQ-1:0]   grant,
  output logic              busy,
  output logic              timeout_evt
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic {
    IDLE,
    LOCK
  } state_e;

  state_e          state_q, state_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic [PW-1:0]   owner_q, owner_d;
  logic [PW-1:0]   last_ptr_q, last_ptr_d;

  logic            pick_found;
  logic [PW-1:0]   pick_idx;
  logic            owner_valid;
  logic            owner_last;
  logic            xfer;
  logic            tmo_hit;

  assign owner_valid = req_valid[owner_q];
  assign owner_last  = req_last[owner_q];
  assign xfer = (state_q == LOCK) & owner_valid
              & ~tx_full & ~Rst;

  // Round-robin search starting just after the last owner
  always_comb begin
    int c;
    c          = 0;
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int k = NREQ; k >= 1; k--) begin
      c = (int'(last_ptr_q) + k) % NREQ;
      if (req_valid[c]) begin
        pick_found = 1'b1;
        pick_idx   = PW'(c);
      end
    end
  end

  // State register: arbitration state, owner and rotation pointer
  always_ff @(posedge clk) begin
    if (Rst) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      owner_q    <= '0;
      last_ptr_q <= PW'(NREQ - 1);
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      owner_q    <= owner_d;
      last_ptr_q <= last_ptr_d;
    end
  end

  // Next state: grant on a one-cycle arbitration, release on last byte
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    owner_d    = owner_q;
    last_ptr_d = last_ptr_q;
    unique case (state_q)
      IDLE: begin
        if (pick_found) begin
          state_d = LOCK;
          grant_d = {{(NREQ-1){1'b0}}, 1'b1} << pick_idx;
          owner_d = pick_idx;
        end
      end
      LOCK: begin
        if ((xfer && owner_last) || tmo_hit) begin
          state_d    = IDLE;
          grant_d    = '0;
          last_ptr_d = owner_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs: owner's byte passes straight through to the tx FIFO
  always_comb begin
    req_ready = '0;
    tx_wen    = 1'b0;
    uart_din  = 8'h00;
    if (state_q == LOCK) begin
      req_ready[owner_q] = ~tx_full & ~Rst;
      tx_wen             = xfer;
      uart_din           = req_data[8*int'(owner_q) +: 8];
    end
  end

  assign grant = grant_q;
  assign busy  = (state_q == LOCK);

`ifdef UART_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);

  logic [TW-1:0] timer_q, timer_d;
  logic          timeout_evt_q, timeout_evt_d;

  assign tmo_hit = (state_q == LOCK) & ~owner_valid
                 & (timer_q == TW'(TIMEOUT - 1));

  // Idle-cycle timer: cleared by transfers, frozen by tx_full stalls
  always_comb begin
    timer_d       = '0;
    timeout_evt_d = tmo_hit;
    if (state_q == LOCK) begin
      timer_d = timer_q;
      if (xfer || tmo_hit) begin
        timer_d = '0;
      end else if (!owner_valid) begin
        timer_d = timer_q + TW'(1);
      end
    end
  end

  // Timer and release pulse registers
  always_ff @(posedge clk) begin
    if (Rst) begin
      timer_q       <= '0;
      timeout_evt_q <= 1'b0;
    end else begin
      timer_q       <= timer_d;
      timeout_evt_q <= timeout_evt_d;
    end
  end

  assign timeout_evt = timeout_evt_q;
`else
  logic unused_cfg;

  assign unused_cfg  = (TIMEOUT > 0);
  assign tmo_hit     = 1'b0;
  assign timeout_evt = 1'b0;
`endif

endmodule
